ahb_manager_mux: RTL

- N-channel command front-end for the AHB manager.
- Arbitrates N independent user command ports onto the single user interface of ahb_manager_top (stall/idle/first_xfer protocol).
- Arbitration is round-robin and locked for a whole burst.
- Read responses are routed back to the issuing channel through an in-order channel-tag FIFO, so several clients share one AHB manager without interleaving bursts.

---
 rtl/ahb_manager_mux.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_manager_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_manager_mux
//  Description : N-channel command front-end for the AHB manager. Round-robin
//                arbitration locked for a whole burst, combinational forwarding
//                of the granted channel, and an in-order channel-tag FIFO that
//                routes read responses back to the issuing channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_manager_mux #(
    parameter int NUM_CH    = 4,
    parameter int DATA_WDT  = 32,
    parameter int BEAT_WDT  = 32,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         i_hclk,
    input  logic                         i_hreset_n,
    input  logic [NUM_CH-1:0]            i_ch_idle,
    input  logic [NUM_CH-1:0]            i_ch_first_xfer,
    input  logic [NUM_CH-1:0]            i_ch_last,
    input  logic [NUM_CH-1:0]            i_ch_wr,
    input  logic [NUM_CH-1:0]            i_ch_rd,
    input  logic [NUM_CH-1:0]            i_ch_wr_data_dav,
    input  logic [NUM_CH*DATA_WDT-1:0]   i_ch_wr_data,
    input  logic [NUM_CH*32-1:0]         i_ch_addr,
    input  logic [NUM_CH*3-1:0]          i_ch_size,
    input  logic [NUM_CH*BEAT_WDT-1:0]   i_ch_min_len,
    output logic [NUM_CH-1:0]            o_ch_stall,
    output logic [NUM_CH-1:0]            o_ch_dav,
    output logic [DATA_WDT-1:0]          o_rsp_data,
    output logic [31:0]                  o_rsp_addr,
    output logic                         o_idle,
    output logic                         o_first_xfer,
    output logic                         o_wr,
    output logic                         o_rd,
    output logic                         o_wr_data_dav,
    output logic [DATA_WDT-1:0]          o_wr_data,
    output logic [31:0]                  o_addr,
    output logic [2:0]                   o_size,
    output logic [BEAT_WDT-1:0]          o_min_len,
    input  logic                         i_stall,
    input  logic [DATA_WDT-1:0]          i_data,
    input  logic [31:0]                  i_addr,
    input  logic                         i_dav
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(TAG_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [CH_W-1:0]     tag_mem_q [TAG_DEPTH];
    logic [CH_W-1:0]     tag_mem_d [TAG_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [NUM_CH-1:0]   ch_dav_q, ch_dav_d;
    logic [DATA_WDT-1:0] rsp_data_q, rsp_data_d;
    logic [31:0]         rsp_addr_q, rsp_addr_d;

    logic [NUM_CH-1:0]   req;
    logic                req_hit;
    logic [CH_W-1:0]     req_pick;
    logic                grant_stall;
    logic                beat_accept;
    logic                tag_full;
    logic                tag_empty;
    logic                push;
    logic                pop;

    // Channel index 'offset' places above 'base', wrapped to NUM_CH.
    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int offset);
        logic [CH_W:0] sum;
        sum = {1'b0, base} + (CH_W+1)'(offset);
        if (sum >= (CH_W+1)'(NUM_CH)) begin
            sum = sum - (CH_W+1)'(NUM_CH);
        end
        return sum[CH_W-1:0];
    endfunction

    assign req       = i_ch_first_xfer & ~i_ch_idle;
    assign tag_empty = (wr_ptr_q == rd_ptr_q);
    assign tag_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign push      = o_rd & ~i_stall & ~o_idle;
    assign pop       = i_dav & ~tag_empty;

    // Round-robin search: first requester at or above rr_ptr wins.
    always_comb begin
        req_hit  = 1'b0;
        req_pick = rr_ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!req_hit && req[rr_index(rr_ptr_q, i)]) begin
                req_hit  = 1'b1;
                req_pick = rr_index(rr_ptr_q, i);
            end
        end
    end

    // Forward the granted channel downstream; everyone else is held off.
    always_comb begin
        o_idle        = 1'b1;
        o_first_xfer  = 1'b0;
        o_wr          = 1'b0;
        o_rd          = 1'b0;
        o_wr_data_dav = 1'b0;
        o_wr_data     = '0;
        o_addr        = '0;
        o_size        = '0;
        o_min_len     = '0;
        o_ch_stall    = '1;
        grant_stall   = 1'b1;
        if (state_q == ST_BURST) begin
            // A read is held back while every tag slot is in use.
            grant_stall         = i_stall | (i_ch_rd[grant_q] & tag_full);
            o_ch_stall[grant_q] = grant_stall;
            o_idle              = i_ch_idle[grant_q];
            o_first_xfer        = i_ch_first_xfer[grant_q];
            o_wr                = i_ch_wr[grant_q];
            o_rd                = i_ch_rd[grant_q] & ~tag_full;
            o_wr_data_dav       = i_ch_wr_data_dav[grant_q];
            o_wr_data           = i_ch_wr_data[int'(grant_q)*DATA_WDT +: DATA_WDT];
            o_addr              = i_ch_addr[int'(grant_q)*32 +: 32];
            o_size              = i_ch_size[int'(grant_q)*3 +: 3];
            o_min_len           = i_ch_min_len[int'(grant_q)*BEAT_WDT +: BEAT_WDT];
        end
    end

    // Arbitration FSM next state: grant in ARB, release after the last beat.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_accept = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (req_hit) begin
                    grant_d = req_pick;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                beat_accept = ~grant_stall & ~i_ch_idle[grant_q];
                if (beat_accept && i_ch_last[grant_q]) begin
                    rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);
                    state_d  = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Tag FIFO: remember which channel issued each accepted read.
    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push) begin
            tag_mem_d[wr_ptr_q[IDX_W-1:0]] = grant_q;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Response path: steer each returned beat to the channel at the FIFO head.
    always_comb begin
        ch_dav_d   = '0;
        rsp_data_d = rsp_data_q;
        rsp_addr_d = rsp_addr_q;
        if (pop) begin
            ch_dav_d[tag_mem_q[rd_ptr_q[IDX_W-1:0]]] = 1'b1;
            rsp_data_d = i_data;
            rsp_addr_d = i_addr;
        end
    end

    // State registers with asynchronous reset; reset drops outstanding tags.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ch_dav_q   <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ch_dav_q   <= ch_dav_d;
            rsp_data_q <= rsp_data_d;
            rsp_addr_q <= rsp_addr_d;
            tag_mem_q  <= tag_mem_d;
        end
    end

    assign o_ch_dav   = ch_dav_q;
    assign o_rsp_data = rsp_data_q;
    assign o_rsp_addr = rsp_addr_q;

    // A response with no outstanding read is a downstream contract violation.
    a_no_orphan_dav: assert property (@(posedge i_hclk) disable iff (!i_hreset_n)
                                      !(i_dav && tag_empty));

endmodule
`default_nettype wire
